// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common-data-bus arbiter.
// Build option: CDB_BYPASS_EN lets fresh requests win in the same cycle.
package cdb_pkg;

  localparam int CDB_TAG_W  = 5;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_msg_t;

  function automatic int unsigned rr_next(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// Round-robin pick of up to two candidates starting at ptr.
// Shared with the issue scheduler; purely combinational.
module rr_pick2 #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  cand,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] gnt0_idx,
  output logic             gnt0_v,
  output logic [PTR_W-1:0] gnt1_idx,
  output logic             gnt1_v
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt0_idx = '0;
    gnt0_v   = 1'b0;
    gnt1_idx = '0;
    gnt1_v   = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + PTR_W'(k);
      if (cand[idx]) begin
        if (!gnt0_v) begin
          gnt0_v   = 1'b1;
          gnt0_idx = idx;
        end else if (!gnt1_v) begin
          gnt1_v   = 1'b1;
          gnt1_idx = idx;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-port CDB broadcast arbiter with a one-entry hold per producer.
// Build option: CDB_BYPASS_EN (empty-hold requests compete directly).
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*TAG_W-1:0]  req_tag,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   bus0_valid,
  output logic [TAG_W-1:0]       bus0_tag,
  output logic [DATA_W-1:0]      bus0_data,
  output logic                   bus1_valid,
  output logic [TAG_W-1:0]       bus1_tag,
  output logic [DATA_W-1:0]      bus1_data
);

  localparam int PTR_W = $clog2(NREQ);

  logic [NREQ-1:0]   hold_v;
  logic [TAG_W-1:0]  hold_tag  [NREQ];
  logic [DATA_W-1:0] hold_data [NREQ];
  logic [PTR_W-1:0]  ptr;
  cdb_msg_t          bus0_q, bus1_q;

  logic [NREQ-1:0]   cand, grant, accept, direct;
  logic [PTR_W-1:0]  g0, g1;
  logic              g0_v, g1_v;
  cdb_msg_t          pick0, pick1;

`ifdef CDB_BYPASS_EN
  assign cand = hold_v | (req_valid & ~hold_v);
`else
  assign cand = hold_v;
`endif

  rr_pick2 #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .cand     (cand),
    .ptr      (ptr),
    .gnt0_idx (g0),
    .gnt0_v   (g0_v),
    .gnt1_idx (g1),
    .gnt1_v   (g1_v)
  );

  always_comb begin
    grant = '0;
    if (g0_v) grant[g0] = 1'b1;
    if (g1_v) grant[g1] = 1'b1;
  end

  assign req_ready = {NREQ{~flush}} & (~hold_v | grant);
  assign accept    = req_valid & req_ready;
  // a granted empty slot means the request went straight to a bus
  assign direct    = grant & ~hold_v;

  always_comb begin
    pick0 = '0;
    pick1 = '0;
    if (g0_v) begin
      pick0.valid = 1'b1;
      pick0.tag   = hold_v[g0] ? hold_tag[g0]
                  : req_tag[int'(g0)*TAG_W +: TAG_W];
      pick0.data  = hold_v[g0] ? hold_data[g0]
                  : req_data[int'(g0)*DATA_W +: DATA_W];
    end
    if (g1_v) begin
      pick1.valid = 1'b1;
      pick1.tag   = hold_v[g1] ? hold_tag[g1]
                  : req_tag[int'(g1)*TAG_W +: TAG_W];
      pick1.data  = hold_v[g1] ? hold_data[g1]
                  : req_data[int'(g1)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v <= '0;
      ptr    <= '0;
      bus0_q <= '0;
      bus1_q <= '0;
    end else if (flush) begin
      hold_v <= '0;
      bus0_q <= '0;
      bus1_q <= '0;
    end else begin
      bus0_q <= pick0;
      bus1_q <= pick1;
      if (g1_v)
        ptr <= PTR_W'(rr_next(int'(g1), NREQ));
      else if (g0_v)
        ptr <= PTR_W'(rr_next(int'(g0), NREQ));
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i] && !direct[i])
          hold_v[i] <= 1'b1;
        else if (grant[i])
          hold_v[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        hold_tag[i]  <= '0;
        hold_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i] && !direct[i]) begin
          hold_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
          hold_data[i] <= req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign bus0_valid = bus0_q.valid;
  assign bus0_tag   = bus0_q.tag;
  assign bus0_data  = bus0_q.data;
  assign bus1_valid = bus1_q.valid;
  assign bus1_tag   = bus1_q.tag;
  assign bus1_data  = bus1_q.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-based model.
// Honors CDB_BYPASS_EN the same way the design does.
module tb_cdb_arbiter;

`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         flush;
  logic [3:0]   req_valid;
  logic [19:0]  req_tag;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         bus0_valid, bus1_valid;
  logic [4:0]   bus0_tag, bus1_tag;
  logic [31:0]  bus0_data, bus1_data;

  cdb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_tag    (req_tag),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .bus0_valid (bus0_valid),
    .bus0_tag   (bus0_tag),
    .bus0_data  (bus0_data),
    .bus1_valid (bus1_valid),
    .bus1_tag   (bus1_tag),
    .bus1_data  (bus1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;
  int sat_cnt = 0;

  bit          m_hv [4];
  logic [4:0]  m_ht [4];
  logic [31:0] m_hd [4];
  int          m_ptr;
  bit          m_bv [2];
  logic [4:0]  m_bt [2];
  logic [31:0] m_bd [2];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 4; i++) begin
      m_hv[i] = 1'b0;
      m_ht[i] = '0;
      m_hd[i] = '0;
    end
    for (int b = 0; b < 2; b++) begin
      m_bv[b] = 1'b0;
      m_bt[b] = '0;
      m_bd[b] = '0;
    end
    m_ptr = 0;
  endtask

  task automatic step(input logic [3:0] v, input logic [19:0] t,
                      input logic [127:0] d, input bit fl);
    int q[$];
    bit gr [4];
    logic [3:0] rdy;
    int n, src;
    @(negedge clk);
    req_valid = v;
    req_tag   = t;
    req_data  = d;
    flush     = fl;
    #1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (m_hv[i] || (BYP && v[i])) q.push_back(i);
    end
    n = (q.size() > 2) ? 2 : q.size();
    for (int i = 0; i < 4; i++) gr[i] = 1'b0;
    for (int j = 0; j < n; j++) gr[q[j]] = 1'b1;
    for (int i = 0; i < 4; i++) rdy[i] = !fl && (!m_hv[i] || gr[i]);
    chk("ready", 64'(req_ready), 64'(rdy));
    @(posedge clk);
    #1;
    if (fl) begin
      for (int i = 0; i < 4; i++) m_hv[i] = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_bv[b] = 1'b0; m_bt[b] = '0; m_bd[b] = '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (b < n) begin
          src = q[b];
          m_bv[b] = 1'b1;
          m_bt[b] = m_hv[src] ? m_ht[src] : t[src*5 +: 5];
          m_bd[b] = m_hv[src] ? m_hd[src] : d[src*32 +: 32];
        end else begin
          m_bv[b] = 1'b0; m_bt[b] = '0; m_bd[b] = '0;
        end
      end
      if (n > 0) m_ptr = (q[n-1] + 1) % 4;
      for (int i = 0; i < 4; i++) begin
        if (v[i] && rdy[i] && !(gr[i] && !m_hv[i])) begin
          m_hv[i] = 1'b1;
          m_ht[i] = t[i*5 +: 5];
          m_hd[i] = d[i*32 +: 32];
        end else if (gr[i]) begin
          m_hv[i] = 1'b0;
        end
      end
    end
    chk("b0v", 64'(bus0_valid), 64'(m_bv[0]));
    chk("b0t", 64'(bus0_tag),   64'(m_bt[0]));
    chk("b0d", 64'(bus0_data),  64'(m_bd[0]));
    chk("b1v", 64'(bus1_valid), 64'(m_bv[1]));
    chk("b1t", 64'(bus1_tag),   64'(m_bt[1]));
    chk("b1d", 64'(bus1_data),  64'(m_bd[1]));
    sat_cnt += int'(bus0_valid) + int'(bus1_valid);
  endtask

  task automatic idle();
    step(4'b0, 20'b0, 128'b0, 1'b0);
  endtask

  function automatic logic [127:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    req_valid = '0;
    req_tag = '0;
    req_data = '0;
    mreset();
    #2;
    chk("rst_b0v", 64'(bus0_valid), 64'd0);
    chk("rst_b1v", 64'(bus1_valid), 64'd0);
    chk("rst_rdy", 64'(req_ready), 64'hf);
    @(negedge clk);
    rst = 1'b1;

    // four at once from ptr=0
    step(4'hf, {5'd4, 5'd3, 5'd2, 5'd1}, rnd_data(), 1'b0);
    if (!BYP) idle();
    chk("four_b0", 64'(bus0_tag), 64'd1);
    chk("four_b1", 64'(bus1_tag), 64'd2);
    idle();
    chk("four_b0n", 64'(bus0_tag), 64'd3);
    chk("four_b1n", 64'(bus1_tag), 64'd4);
    idle();

    // single request
    step(4'b0001, {15'd0, 5'h03}, {96'd0, 32'hDEAD_BEEF}, 1'b0);
    if (!BYP) idle();
    chk("one_v",  64'(bus0_valid), 64'd1);
    chk("one_t",  64'(bus0_tag),   64'h03);
    chk("one_d",  64'(bus0_data),  64'hDEAD_BEEF);
    chk("one_b1", 64'(bus1_valid), 64'd0);

    // wrap: move ptr to 3, then 3 and 0 compete
    step(4'b0100, {5'd0, 5'h0a, 10'd0}, rnd_data(), 1'b0);
    if (!BYP) idle();
    step(4'b1001, {5'h1d, 10'd0, 5'h05}, rnd_data(), 1'b0);
    if (!BYP) idle();
    chk("wrap_b0", 64'(bus0_tag), 64'h1d);
    chk("wrap_b1", 64'(bus1_tag), 64'h05);
    idle();

    // flush with holds full and buses busy
    for (int k = 0; k < 3; k++) step(4'hf, 20'($urandom), rnd_data(), 1'b0);
    step(4'hf, 20'($urandom), rnd_data(), 1'b1);
    chk("fl_b0v", 64'(bus0_valid), 64'd0);
    chk("fl_b1v", 64'(bus1_valid), 64'd0);
    idle();
    chk("fl_drop", 64'(bus0_valid), 64'd0);
    step(4'b0100, {5'd0, 5'h07, 10'd0}, rnd_data(), 1'b0);
    if (!BYP) idle();
    chk("fl_new", 64'(bus0_tag), 64'h07);

    // saturation from an empty state
    step(4'h0, 20'b0, 128'b0, 1'b1);
    sat_cnt = 0;
    for (int k = 0; k < 20; k++) step(4'hf, 20'($urandom), rnd_data(), 1'b0);
    chk("sat_cnt", 64'(sat_cnt), BYP ? 64'd40 : 64'd38);

    // random traffic
    for (int k = 0; k < 400; k++)
      step(4'($urandom), 20'($urandom), rnd_data(),
           $urandom_range(0, 19) == 0);

    // async reset between edges
    for (int k = 0; k < 4; k++) step(4'hf, 20'($urandom), rnd_data(), 1'b0);
    @(negedge clk);
    req_valid = '0;
    flush = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("ar_b0v", 64'(bus0_valid), 64'd0);
    chk("ar_b1v", 64'(bus1_valid), 64'd0);
    chk("ar_b0t", 64'(bus0_tag),   64'd0);
    chk("ar_rdy", 64'(req_ready),  64'hf);
    mreset();
    #1;
    rst = 1'b1;
    step(4'b1010, {5'h11, 5'd0, 5'h0c, 5'd0}, rnd_data(), 1'b0);
    if (!BYP) idle();
    chk("ar_b0", 64'(bus0_tag), 64'h0c);
    chk("ar_b1", 64'(bus1_tag), 64'h11);
    idle();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
